// File: rtl/wb_scoreboard.sv
// wb_scoreboard: register pending-bit scoreboard with a write-back arbiter.
// Tracks which architectural registers have a result in flight, stalls
// decode on hazards, and merges the single-cycle ALU result stream and the
// long-latency result stream onto one registered register-file write port.
// Optional feature macro: WB_BYPASS_EN (adds rs1_fwd/rs2_fwd and lets a
// source operand whose write is on the write port this cycle proceed).
//
// Handshake: a long result transfers on a rising edge where
// long_valid & long_ready are both 1. The producer holds long_rd/long_data
// stable while long_valid=1 and long_ready=0. An ALU result (alu_valid=1)
// is always taken in the cycle it is presented. An instruction issues on
// the edge where issue_valid=1 and stall=0; decode holds it otherwise.
module wb_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int REG_WIDTH      = 32,
    parameter int REGFILE_DEPTH  = 32
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] issue_rs2,
    input  logic                      issue_long,
    output logic                      stall,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
    input  logic [REG_WIDTH-1:0]      alu_data,
    input  logic                      long_valid,
    input  logic [REG_ADDR_WIDTH-1:0] long_rd,
    input  logic [REG_WIDTH-1:0]      long_data,
    output logic                      long_ready,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [REG_WIDTH-1:0]      rd_inp,
    output logic                      write_en
`ifdef WB_BYPASS_EN
    ,
    output logic [REG_WIDTH-1:0]      rs1_fwd,
    output logic [REG_WIDTH-1:0]      rs2_fwd
`endif
);

    // Which port an instruction completes through does not change how its
    // destination is tracked: both ports clear the same pending bit.
    logic unused_issue_long;
    assign unused_issue_long = issue_long;

    logic [REGFILE_DEPTH-1:0]  pending;
    logic [REGFILE_DEPTH-1:0]  pending_nxt;
    logic                      buf_valid;
    logic [REG_ADDR_WIDTH-1:0] buf_rd;
    logic [REG_WIDTH-1:0]      buf_data;
    logic                      long_hs;
    logic                      buf_load;
    logic                      buf_drain;
    logic                      sel_valid;
    logic [REG_ADDR_WIDTH-1:0] sel_rd;
    logic [REG_WIDTH-1:0]      sel_data;
    logic                      rs1_haz;
    logic                      rs2_haz;
    logic                      rd_haz;
    logic                      issue_fire;

    assign long_ready = ~buf_valid;
    assign long_hs    = long_valid & long_ready;

    // Write-source selection: ALU first, then the buffered long result,
    // then a fresh long result straight through. A long result arriving
    // while the ALU owns the port is parked in the buffer.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        buf_load  = 1'b0;
        buf_drain = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
            buf_load  = long_hs;
        end else if (buf_valid) begin
            sel_valid = 1'b1;
            sel_rd    = buf_rd;
            sel_data  = buf_data;
            buf_drain = 1'b1;
        end else if (long_hs) begin
            sel_valid = 1'b1;
            sel_rd    = long_rd;
            sel_data  = long_data;
        end
    end

    // One-entry long-result buffer; reset discards any parked result.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            buf_valid <= 1'b0;
            buf_rd    <= '0;
            buf_data  <= '0;
        end else if (buf_load) begin
            buf_valid <= 1'b1;
            buf_rd    <= long_rd;
            buf_data  <= long_data;
        end else if (buf_drain) begin
            buf_valid <= 1'b0;
        end
    end

    // Registered write port; results to x0 retire without a write strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            write_en <= 1'b0;
            rd_addr  <= '0;
            rd_inp   <= '0;
        end else begin
            write_en <= sel_valid && (sel_rd != '0);
            if (sel_valid) begin
                rd_addr <= sel_rd;
                rd_inp  <= sel_data;
            end
        end
    end

    // Hazard detection; with bypass, a source being written this cycle is
    // forwarded from the write port instead of stalling.
`ifdef WB_BYPASS_EN
    assign rs1_fwd = rd_inp;
    assign rs2_fwd = rd_inp;
    always_comb begin
        rs1_haz = (issue_rs1 != '0) && pending[issue_rs1]
                  && !(write_en && (rd_addr == issue_rs1));
        rs2_haz = (issue_rs2 != '0) && pending[issue_rs2]
                  && !(write_en && (rd_addr == issue_rs2));
        rd_haz  = (issue_rd != '0) && pending[issue_rd];
    end
`else
    always_comb begin
        rs1_haz = (issue_rs1 != '0) && pending[issue_rs1];
        rs2_haz = (issue_rs2 != '0) && pending[issue_rs2];
        rd_haz  = (issue_rd != '0) && pending[issue_rd];
    end
`endif

    assign stall      = issue_valid && (rs1_haz || rs2_haz || rd_haz);
    assign issue_fire = issue_valid && !stall;

    // Next pending state: the write on the port clears, an issue sets, and
    // the set is applied last so it wins on the same register.
    always_comb begin
        pending_nxt = pending;
        if (write_en) begin
            pending_nxt[rd_addr] = 1'b0;
        end
        if (issue_fire && (issue_rd != '0)) begin
            pending_nxt[issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Pending-bit register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 SHALL have parameter REG_ADDR_WIDTH, default 5, register address width.
REQ-002 SHALL have parameter REG_WIDTH, default 32, data width.
REQ-003 SHALL have parameter REGFILE_DEPTH, default 32, number of architectural registers; x0 is hardwired zero.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 issue_valid  input  1  decode presents an instruction.
REQ-007 issue_rd, issue_rs1, issue_rs2  input  REG_ADDR_WIDTH each  destination and source addresses of the presented instruction.
REQ-008 issue_long  input  1  instruction completes through the long-latency port.
REQ-009 stall  output  1  combinational; instruction must be held; not issued this cycle.
REQ-010 alu_valid, alu_rd, alu_data  input  1/REG_ADDR_WIDTH/REG_WIDTH  single-cycle result; always accepted.
REQ-011 long_valid, long_rd, long_data  input  1/REG_ADDR_WIDTH/REG_WIDTH  long-latency result.
REQ-012 long_ready  output  1  long result accepted when long_valid & long_ready.
REQ-013 rd_addr, rd_inp, write_en  output  REG_ADDR_WIDTH/REG_WIDTH/1  registered register-file write port.

Function
REQ-014 SHALL keep one pending bit per register 1..REGFILE_DEPTH-1; register 0 is never pending.
REQ-015 stall SHALL be 1 when issue_valid and any of issue_rs1, issue_rs2, issue_rd (address nonzero) is pending; else 0.
REQ-016 Issue SHALL occur when issue_valid & ~stall; on issue with issue_rd!=0 the pending bit of issue_rd SHALL set next edge.
REQ-017 A one-entry long buffer SHALL hold an accepted long result; long_ready = buffer empty.
REQ-018 Write arbitration per cycle: alu_valid wins; else buffer drains; else a new long handshake result bypasses the buffer directly to the write port.
REQ-019 When alu_valid and a long result is handshaken in the same cycle, the long result SHALL be captured in the buffer.
REQ-020 Write port latency SHALL be exactly 1 cycle from selection: rd_addr/rd_inp/write_en update on the edge after the winning source is selected.
REQ-021 write_en SHALL be 0 for any selected result with destination 0; such results still retire.
REQ-022 On the edge a result is written, its pending bit SHALL clear.
REQ-023 Same-edge set (issue) and clear (writeback) of one register: set SHALL win.
REQ-024 Results for non-pending registers SHALL still be written; pending state unchanged.
REQ-025 Results SHALL never be dropped or reordered within the long port.

Reset
REQ-026 While rstn=0 at a rising edge: all pending bits 0, buffer empty, write_en 0, rd_addr 0, rd_inp 0.
REQ-027 Reset mid-operation SHALL discard buffered and in-flight results; long_ready SHALL be 1 the cycle after reset deasserts.
REQ-028 stall SHALL be 0 during and immediately after reset unless issue_valid meets REQ-015 against cleared state.

Configuration
REQ-029 Macro WB_BYPASS_EN SHALL, when defined, add outputs rs1_fwd, rs2_fwd (REG_WIDTH) and suppress the source-operand hazard for a pending register whose write is on the write port this cycle (write_en & rd_addr match), with rsN_fwd = rd_inp.
REQ-030 Without WB_BYPASS_EN, those ports SHALL not exist and stall SHALL follow REQ-015 exactly.

Verification
REQ-031 Reset: rstn=0 two cycles -> write_en=0, long_ready=1, stall=0 with issue_valid=1, rs1=5.
REQ-032 Issue rd=5 long; next cycle issue rs1=5 -> stall=1 until long result rd=5 written; stall=0 the cycle after write_en=1 with rd_addr=5 (same cycle when WB_BYPASS_EN, rs1_fwd=long_data).
REQ-033 Same cycle alu_valid rd=3 data=0xAAAA and long_valid rd=7 data=0xBBBB -> write rd=3 next cycle, rd=7 following cycle; long_ready=0 in between.
REQ-034 Issue rd=9 on same edge as writeback of rd=9 -> pending[9] remains 1; issue rs2=9 stalls.
REQ-035 alu_valid rd=0 data=0x1234 -> write_en stays 0; issue rd=0 never stalls.
REQ-036 Long result in buffer, rstn=0 one cycle -> no write of that result ever occurs; long_ready=1 after reset.
